tlv_uart_tx_encoder: RTL

- Transmit-side counterpart of the UART TLV loader used by the encapsulation bench.
- Reads 32-bit result words (K, C0, C1) from a synchronous RAM and frames them as TYPE/LENGTH/VALUE byte streams.
- Feeds the frames one byte at a time to the UART Transmitter through a send/done handshake.
- Payloads longer than one frame are split automatically into consecutive frames with the same TYPE.

---
 rtl/tlv_uart_tx_encoder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tlv_uart_tx_encoder.sv
// Frames RAM words as TYPE/LENGTH/VALUE byte streams and sends them to a UART transmitter one byte at a time.
// Payloads longer than WORDS_PER_FRAME words are split into back-to-back frames that carry the same TYPE.
module tlv_uart_tx_encoder #(
  parameter int ADDR_W          = 8,
  parameter int CNT_W           = 9,
  parameter int WORDS_PER_FRAME = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        tlv_type,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_done
);

  localparam int FW_W = $clog2(WORDS_PER_FRAME + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SEND_TYPE = 4'd1;
  localparam logic [3:0] S_WAIT_TYPE = 4'd2;
  localparam logic [3:0] S_SEND_LEN  = 4'd3;
  localparam logic [3:0] S_WAIT_LEN  = 4'd4;
  localparam logic [3:0] S_FETCH     = 4'd5;
  localparam logic [3:0] S_LOAD      = 4'd6;
  localparam logic [3:0] S_SEND_VAL  = 4'd7;
  localparam logic [3:0] S_WAIT_VAL  = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  logic [3:0]        state_q, state_d;
  logic [7:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [FW_W-1:0]   fw_q, fw_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;

  function automatic logic [FW_W-1:0] min_frame(input logic [CNT_W-1:0] r);
    if (r > CNT_W'(WORDS_PER_FRAME)) return FW_W'(WORDS_PER_FRAME);
    return r[FW_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    fw_d    = fw_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (tlv_type != 8'd0 && num_words != '0) begin
            type_d  = tlv_type;
            rem_d   = num_words;
            addr_d  = base_addr;
            fw_d    = min_frame(num_words);
            state_d = S_SEND_TYPE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEND_TYPE: state_d = S_WAIT_TYPE;
      S_WAIT_TYPE: if (tx_done) state_d = S_SEND_LEN;
      S_SEND_LEN:  state_d = S_WAIT_LEN;
      S_WAIT_LEN:  if (tx_done) state_d = S_FETCH;
      S_FETCH:     state_d = S_LOAD;
      S_LOAD: begin
        shreg_d = mem_rdata;
        idx_d   = 2'd0;
        state_d = S_SEND_VAL;
      end
      S_SEND_VAL:  state_d = S_WAIT_VAL;
      S_WAIT_VAL: begin
        if (tx_done) begin
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            shreg_d = {shreg_q[23:0], 8'h00};
            state_d = S_SEND_VAL;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - CNT_W'(1);
            fw_d   = fw_q - FW_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = S_DONE;
            end else if (fw_q == FW_W'(1)) begin
              fw_d    = min_frame(rem_q - CNT_W'(1));
              state_d = S_SEND_TYPE;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= 8'd0;
      addr_q  <= '0;
      rem_q   <= '0;
      fw_q    <= '0;
      shreg_q <= 32'd0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      fw_q    <= fw_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign mem_rd   = (state_q == S_FETCH);
  assign mem_addr = addr_q;
  assign tx_send  = (state_q == S_SEND_TYPE) || (state_q == S_SEND_LEN) || (state_q == S_SEND_VAL);

  // The byte is a pure function of state, so it stays stable for the whole SEND/WAIT pair.
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      S_SEND_TYPE, S_WAIT_TYPE: tx_data = type_q;
      S_SEND_LEN, S_WAIT_LEN:   tx_data = 8'({fw_q, 2'b00});
      S_SEND_VAL, S_WAIT_VAL:   tx_data = shreg_q[31:24];
      default:                  tx_data = 8'h00;
    endcase
  end

endmodule
